// File: rtl/gpu_pkg.sv
// Shared definitions for the warp register file: special register addresses,
// the GP register count and the clear-sweep FSM state type.
package gpu_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int NUM_GP_REGS = 28;

  localparam reg_addr_t REG_TIDX = 5'd28;
  localparam reg_addr_t REG_BIDX = 5'd29;
  localparam reg_addr_t REG_BDIM = 5'd30;
  localparam reg_addr_t REG_LID  = 5'd31;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_e;

endpackage

// File: rtl/special_reg_mux.sv
// Decodes a read address into either a GP-bank select or a hardware special
// register value (tIdx, bIdx, bDim, lId); x0 decodes to a constant zero.
module special_reg_mux
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = 16,
  parameter int DATA_W      = 32,
  parameter int BLOCK_DIM   = 1,
  parameter int LANE_W      = 8
) (
  input  reg_addr_t                  addr,
  input  logic [$clog2(NUM_THREADS)-1:0] thread,
  input  logic [DATA_W-1:0]          bidx,
  output logic                       is_gp,
  output logic [DATA_W-1:0]          value
);

  always_comb begin
    is_gp = 1'b0;
    value = '0;
    case (addr)
      5'd0:     value = '0;
      REG_TIDX: value = DATA_W'(thread);
      REG_BIDX: value = bidx;
      REG_BDIM: value = DATA_W'(BLOCK_DIM);
      REG_LID:  value = DATA_W'(32'(thread) % LANE_W);
      default:  is_gp = 1'b1;
    endcase
  end

endmodule

// File: rtl/warp_regfile.sv
// Per-thread GP register banks with masked broadcast write, registered reads
// with write forwarding, per-thread predicates and a post-reset zeroing sweep.
module warp_regfile
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS = 16,
  parameter int DATA_W      = 32,
  parameter int NUM_PRED    = 4,
  parameter int BLOCK_DIM   = 1,
  parameter int LANE_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rd_en,
  input  logic [$clog2(NUM_THREADS)-1:0]  rd_thread,
  input  logic [4:0]                      rd_addr1,
  input  logic [4:0]                      rd_addr2,
  output logic [DATA_W-1:0]               rd_data1,
  output logic [DATA_W-1:0]               rd_data2,
  output logic                            rd_valid,
  input  logic                            wr_en,
  input  logic [NUM_THREADS-1:0]          wr_mask,
  input  logic [4:0]                      wr_addr,
  input  logic [NUM_THREADS*DATA_W-1:0]   wr_data,
  input  logic                            pred_wr_en,
  input  logic [$clog2(NUM_PRED)-1:0]     pred_wr_idx,
  input  logic [NUM_THREADS-1:0]          pred_wr_mask,
  input  logic [NUM_THREADS-1:0]          pred_wr_val,
  input  logic [$clog2(NUM_PRED)-1:0]     pred_rd_idx,
  output logic [NUM_THREADS-1:0]          pred_out,
  input  logic [DATA_W-1:0]               bIdx,
  output logic                            busy
);

  regfile_state_e state;
  reg_addr_t      clr_idx;
  logic           run;
  logic           wr_ok;

  logic [NUM_THREADS-1:0][DATA_W-1:0] wr_vec;
  logic [DATA_W-1:0] word1 [NUM_THREADS];
  logic [DATA_W-1:0] word2 [NUM_THREADS];

  logic              gp1, gp2, fwd1, fwd2;
  logic [DATA_W-1:0] spec1, spec2, next1, next2;

  logic [NUM_PRED-1:0][NUM_THREADS-1:0] pred;

  assign run    = (state == RUN);
  assign wr_vec = wr_data;
  assign wr_ok  = wr_en && run && (wr_addr != 5'd0) && (wr_addr < REG_TIDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_idx == reg_addr_t'(NUM_GP_REGS - 1)) begin
        state <= RUN;
        busy  <= 1'b0;
      end else begin
        clr_idx <= clr_idx + 5'd1;
      end
    end
  end

  // One single-write-port bank per thread; the sweep shares that port so no
  // bank needs a reset, keeping each one RAM-inferable.
  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_bank
    logic [DATA_W-1:0] bank [NUM_GP_REGS];

    always_ff @(posedge clk) begin
      if (!run) begin
        bank[clr_idx] <= '0;
      end else if (wr_ok && wr_mask[g]) begin
        bank[wr_addr] <= wr_vec[g];
      end
    end

    assign word1[g] = bank[rd_addr1];
    assign word2[g] = bank[rd_addr2];
  end

  special_reg_mux #(
    .NUM_THREADS(NUM_THREADS), .DATA_W(DATA_W), .BLOCK_DIM(BLOCK_DIM), .LANE_W(LANE_W)
  ) u_mux1 (
    .addr(rd_addr1), .thread(rd_thread), .bidx(bIdx), .is_gp(gp1), .value(spec1)
  );

  special_reg_mux #(
    .NUM_THREADS(NUM_THREADS), .DATA_W(DATA_W), .BLOCK_DIM(BLOCK_DIM), .LANE_W(LANE_W)
  ) u_mux2 (
    .addr(rd_addr2), .thread(rd_thread), .bidx(bIdx), .is_gp(gp2), .value(spec2)
  );

  assign fwd1  = wr_ok && wr_mask[rd_thread] && (wr_addr == rd_addr1);
  assign fwd2  = wr_ok && wr_mask[rd_thread] && (wr_addr == rd_addr2);
  assign next1 = !gp1 ? spec1 : (fwd1 ? wr_vec[rd_thread] : word1[rd_thread]);
  assign next2 = !gp2 ? spec2 : (fwd2 ? wr_vec[rd_thread] : word2[rd_thread]);

  // Read stage: request sampled here, data presented the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      rd_valid <= run && rd_en;
      if (run && rd_en) begin
        rd_data1 <= next1;
        rd_data2 <= next2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred <= '0;
    end else if (run && pred_wr_en) begin
      pred[pred_wr_idx] <= (pred[pred_wr_idx] & ~pred_wr_mask) | (pred_wr_val & pred_wr_mask);
    end
  end

  assign pred_out = pred[pred_rd_idx];

endmodule

// File: tb/tb_warp_regfile.sv
// Directed bench for warp_regfile: read expectations are queued when a read is
// issued and checked when the registered result appears.
module tb_warp_regfile;

  localparam int NT = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rd_en;
  logic [3:0]      rd_thread;
  logic [4:0]      rd_addr1, rd_addr2;
  logic [DW-1:0]   rd_data1, rd_data2;
  logic            rd_valid;
  logic            wr_en;
  logic [NT-1:0]   wr_mask;
  logic [4:0]      wr_addr;
  logic [NT*DW-1:0] wr_data;
  logic            pred_wr_en;
  logic [1:0]      pred_wr_idx;
  logic [NT-1:0]   pred_wr_mask, pred_wr_val;
  logic [1:0]      pred_rd_idx;
  logic [NT-1:0]   pred_out;
  logic [DW-1:0]   bIdx;
  logic            busy;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] last1, last2;
  int            checks = 0;
  int            errors = 0;
  int            n;

  warp_regfile dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_thread(rd_thread),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_valid(rd_valid), .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr),
    .wr_data(wr_data), .pred_wr_en(pred_wr_en), .pred_wr_idx(pred_wr_idx),
    .pred_wr_mask(pred_wr_mask), .pred_wr_val(pred_wr_val), .pred_rd_idx(pred_rd_idx),
    .pred_out(pred_out), .bIdx(bIdx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one edge, then check whatever the read pipeline owes us.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("rd_data1", rd_data1, e.d1);
      chk("rd_data2", rd_data2, e.d2);
      last1 = e.d1;
      last2 = e.d2;
    end else begin
      chk("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
      chk("rd_data1_hold", rd_data1, last1);
      chk("rd_data2_hold", rd_data2, last2);
    end
  endtask

  task automatic rd(input logic [3:0] thr, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    rd_en     = 1'b1;
    rd_thread = thr;
    rd_addr1  = a1;
    rd_addr2  = a2;
    e.d1 = e1;
    e.d2 = e2;
    q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic set_wr(input logic [NT-1:0] m, input logic [4:0] a, input logic [DW-1:0] base,
                        input logic add_thread);
    wr_en   = 1'b1;
    wr_mask = m;
    wr_addr = a;
    for (int t = 0; t < NT; t++)
      wr_data[t*DW +: DW] = base + (add_thread ? DW'(t) : '0);
  endtask

  task automatic count_busy(input int wr_at);
    n = 0;
    do begin
      if (n == wr_at) begin
        set_wr({NT{1'b1}}, 5'd2, 32'h5555_0000, 1'b0);
        pred_wr_en = 1'b1; pred_wr_idx = 2'd1; pred_wr_mask = '1; pred_wr_val = '1;
      end
      tick();
      if (n == wr_at) begin
        wr_en = 1'b0;
        pred_wr_en = 1'b0;
      end
      n++;
    end while (busy && n < 100);
    chk("busy_cycles", n, 28);
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; rd_thread = '0; rd_addr1 = '0; rd_addr2 = '0;
    wr_en = 1'b0; wr_mask = '0; wr_addr = '0; wr_data = '0;
    pred_wr_en = 1'b0; pred_wr_idx = '0; pred_wr_mask = '0; pred_wr_val = '0;
    pred_rd_idx = '0; bIdx = '0; last1 = '0; last2 = '0;

    // Reset: two cycles low, then the sweep; rd_en held high during busy must be ignored.
    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_pred", {16'd0, pred_out}, 32'd0);
    rst_n = 1'b1;
    rd_en = 1'b1; rd_thread = 4'd1; rd_addr1 = 5'd28; rd_addr2 = 5'd30;
    count_busy(-1);
    rd_en = 1'b0;
    rd(4'd5, 5'd7, 5'd0, 32'd0, 32'd0);

    // Broadcast write to threads 4..7 of x3.
    set_wr(16'h00F0, 5'd3, 32'h100, 1'b1);
    tick();
    wr_en = 1'b0;
    for (int t = 4; t < 8; t++)
      rd(4'(t), 5'd3, 5'd3, 32'h100 + 32'(t), 32'h100 + 32'(t));
    rd(4'd0, 5'd3, 5'd3, 32'd0, 32'd0);
    rd(4'd8, 5'd3, 5'd0, 32'd0, 32'd0);

    // Special registers.
    bIdx = 32'h2A;
    rd(4'd11, 5'd28, 5'd31, 32'd11, 32'd3);
    rd(4'd11, 5'd29, 5'd30, 32'h2A, 32'd1);
    rd(4'd14, 5'd31, 5'd28, 32'd6, 32'd14);
    bIdx = 32'h0;

    // Forwarding on each port independently.
    set_wr(16'h0004, 5'd9, 32'hDEADBEEF, 1'b0);
    rd(4'd2, 5'd9, 5'd0, 32'hDEADBEEF, 32'd0);
    wr_en = 1'b0;
    rd(4'd2, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF);
    set_wr(16'h0004, 5'd9, 32'h1234_5678, 1'b0);
    rd(4'd2, 5'd0, 5'd9, 32'd0, 32'h1234_5678);
    set_wr(16'h0008, 5'd9, 32'hCAFE_0000, 1'b0);
    rd(4'd2, 5'd9, 5'd9, 32'h1234_5678, 32'h1234_5678);
    wr_en = 1'b0;
    rd(4'd3, 5'd9, 5'd4, 32'hCAFE_0000, 32'd0);

    // Illegal destinations with a full mask, and an empty-mask write.
    set_wr({NT{1'b1}}, 5'd0, 32'hAAAA_0000, 1'b1);
    rd(4'd3, 5'd0, 5'd0, 32'd0, 32'd0);
    set_wr({NT{1'b1}}, 5'd28, 32'hBBBB_0000, 1'b1);
    rd(4'd3, 5'd28, 5'd3, 32'd3, 32'd0);
    set_wr(16'h0000, 5'd5, 32'hCCCC_0000, 1'b0);
    tick();
    wr_en = 1'b0;
    rd(4'd3, 5'd0, 5'd28, 32'd0, 32'd3);
    rd(4'd9, 5'd5, 5'd5, 32'd0, 32'd0);

    // Predicates.
    pred_wr_en = 1'b1; pred_wr_idx = 2'd1; pred_wr_mask = 16'h000F; pred_wr_val = 16'h0005;
    tick();
    pred_wr_en = 1'b0; pred_rd_idx = 2'd1;
    #1 chk("pred_idx1", {16'd0, pred_out}, 32'h0005);
    pred_wr_en = 1'b1; pred_wr_mask = 16'h00F1; pred_wr_val = 16'h00F0;
    tick();
    pred_wr_en = 1'b0;
    #1 chk("pred_idx1_merge", {16'd0, pred_out}, 32'h00F4);
    pred_rd_idx = 2'd0;
    #1 chk("pred_idx0", {16'd0, pred_out}, 32'h0000);

    // Reset mid-sweep, then a write and predicate update during busy.
    set_wr(16'h0020, 5'd7, 32'h7777_0000, 1'b0);
    tick();
    wr_en = 1'b0;
    rd(4'd5, 5'd7, 5'd0, 32'h7777_0000, 32'd0);
    rst_n = 1'b0; last1 = '0; last2 = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("busy_mid_sweep", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy(10);
    rd(4'd5, 5'd7, 5'd2, 32'd0, 32'd0);
    rd(4'd6, 5'd3, 5'd9, 32'd0, 32'd0);
    pred_rd_idx = 2'd1;
    #1 chk("pred_after_busy", {16'd0, pred_out}, 32'h0000);
    tick();
    chk("queue_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
